// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the 2:1 arbitrated stream multiplexer.
package arb_mux_pkg;
  localparam int unsigned ARB_MUX_WIDTH_DEF = 8;
  localparam int unsigned CNT_W             = 16;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return (idx == SRC1) ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/arb_mux_2_1_rr_arb.sv
// rr_arb_2: combinational 2-requester round-robin arbiter; the last_grant
// register lives in the instantiating block.
module rr_arb_2
  import arb_mux_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt     = '0;
    gnt_idx = SRC0;
    case (req)
      2'b01:   gnt_idx = SRC0;
      2'b10:   gnt_idx = SRC1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = SRC0;
    endcase
    if (req != 2'b00)
      gnt = idx_to_onehot(gnt_idx);
  end

endmodule

// File: rtl/arb_mux_2_1.sv
// arb_mux_2_1: round-robin merge of two valid/ready streams into one
// registered output tagged with its source. ARB_MUX_CNT_EN adds per-source
// 16-bit transfer counters.
module arb_mux_2_1
  import arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = ARB_MUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ARB_MUX_CNT_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  logic       last_grant;
  logic [1:0] gnt;
  logic       gnt_idx;
  logic       load;
  logic       xfer;

  rr_arb_2 u_arb (
    .req        ({in1_valid, in0_valid}),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  // Readies are masked by rst so nothing is offered while reset is held.
  always_comb begin
    load      = !out_valid || out_ready;
    in0_ready = load && gnt[0] && !rst;
    in1_ready = load && gnt[1] && !rst;
    xfer      = load && (gnt != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= SRC0;
      last_grant <= SRC1;
    end else if (load) begin
      if (xfer) begin
        out_data   <= (gnt_idx == SRC1) ? in1_data : in0_data;
        out_src    <= gnt_idx;
        out_valid  <= 1'b1;
        last_grant <= gnt_idx;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

`ifdef ARB_MUX_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (xfer) begin
      if (gnt_idx == SRC1)
        grant_cnt1 <= grant_cnt1 + 1'b1;
      else
        grant_cnt0 <= grant_cnt0 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_arb_mux_2_1.sv
// Directed bench for arb_mux_2_1; the counter scenario is built when
// ARB_MUX_CNT_EN is defined.
module tb_arb_mux_2_1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in0_data, in1_data, out_data;
  logic       in0_valid, in1_valid, in0_ready, in1_ready;
  logic       out_src, out_valid, out_ready;
`ifdef ARB_MUX_CNT_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  arb_mux_2_1 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef ARB_MUX_CNT_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b0;
    in0_data = 8'h00; in1_data = 8'h00;
    #1;
    n_vec++; if ({out_valid, out_src, out_data} !== 10'h000) begin n_err++; $display("FAIL por_out got v=%b s=%b d=%h exp 0/0/00", out_valid, out_src, out_data); end
    n_vec++; if ({in0_ready, in1_ready} !== 2'b00) begin n_err++; $display("FAIL por_ready got %b%b exp 00", in0_ready, in1_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in0_valid = 1'b0; in1_valid = 1'b1; in1_data = 8'h5A; out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({out_valid, out_src, out_data} !== {2'b11, 8'h5A}) begin n_err++; $display("FAIL first_accept got v=%b s=%b d=%h exp 1/1/5a", out_valid, out_src, out_data); end
    in1_valid = 1'b0; in0_valid = 1'b1; in0_data = 8'h3C;
    @(posedge clk); #1;
    out_ready = 1'b0; in0_data = 8'h3D;
    #1;
    n_vec++; if ({in0_ready, in1_ready} !== 2'b00) begin n_err++; $display("FAIL held_ready got %b%b exp 00", in0_ready, in1_ready); end
    n_vec++; if ({out_valid, out_src, out_data} !== {2'b10, 8'h3C}) begin n_err++; $display("FAIL pre_rst_out got v=%b s=%b d=%h exp 1/0/3c", out_valid, out_src, out_data); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if ({out_valid, out_src, out_data} !== 10'h000) begin n_err++; $display("FAIL async_rst_out got v=%b s=%b d=%h exp 0/0/00", out_valid, out_src, out_data); end
    n_vec++; if ({in0_ready, in1_ready} !== 2'b00) begin n_err++; $display("FAIL rst_ready got %b%b exp 00", in0_ready, in1_ready); end
    @(negedge clk);
    rst = 1'b0; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_vec++; if ({in0_ready, in1_ready} !== 2'b10) begin n_err++; $display("FAIL post_rst_grant got %b%b exp 10", in0_ready, in1_ready); end
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic       exp_src  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp_data [4] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    logic [7:0] da = 8'hA0, db = 8'hB0;
    out_ready = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in0_data = da; in1_data = db;
      #1;
      n_vec++; if ({in0_ready, in1_ready} !== {~exp_src[k], exp_src[k]}) begin n_err++; $display("FAIL cont_ready[%0d] got %b%b exp %b%b", k, in0_ready, in1_ready, ~exp_src[k], exp_src[k]); end
      @(posedge clk); #1;
      n_vec++; if ({out_valid, out_src, out_data} !== {1'b1, exp_src[k], exp_data[k]}) begin n_err++; $display("FAIL cont_out[%0d] got v=%b s=%b d=%h exp 1/%b/%h", k, out_valid, out_src, out_data, exp_src[k], exp_data[k]); end
      if (exp_src[k]) db = db + 8'h01; else da = da + 8'h01;
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL cont_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_single_stream();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    out_ready = 1'b1; in1_valid = 1'b0; in0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in0_data = vals[k];
      #1;
      n_vec++; if ({in0_ready, in1_ready} !== 2'b10) begin n_err++; $display("FAIL single_ready[%0d] got %b%b exp 10", k, in0_ready, in1_ready); end
      @(posedge clk); #1;
      n_vec++; if ({out_valid, out_src, out_data} !== {2'b10, vals[k]}) begin n_err++; $display("FAIL single_out[%0d] got v=%b s=%b d=%h exp 1/0/%h", k, out_valid, out_src, out_data, vals[k]); end
    end
    in0_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1; in0_valid = 1'b1; in0_data = 8'h71; in1_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0; in0_data = 8'h72; in1_valid = 1'b1; in1_data = 8'h81;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if ({in0_ready, in1_ready} !== 2'b00) begin n_err++; $display("FAIL bp_ready[%0d] got %b%b exp 00", k, in0_ready, in1_ready); end
      @(posedge clk); #1;
      n_vec++; if ({out_valid, out_src, out_data} !== {2'b10, 8'h71}) begin n_err++; $display("FAIL bp_hold[%0d] got v=%b s=%b d=%h exp 1/0/71", k, out_valid, out_src, out_data); end
    end
    out_ready = 1'b1;
    #1;
    n_vec++; if ({in0_ready, in1_ready} !== 2'b01) begin n_err++; $display("FAIL bp_resume_ready got %b%b exp 01", in0_ready, in1_ready); end
    @(posedge clk); #1;
    n_vec++; if ({out_valid, out_src, out_data} !== {2'b11, 8'h81}) begin n_err++; $display("FAIL bp_next got v=%b s=%b d=%h exp 1/1/81", out_valid, out_src, out_data); end
    in1_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++; if ({out_valid, out_src, out_data} !== {2'b10, 8'h72}) begin n_err++; $display("FAIL bp_noloss got v=%b s=%b d=%h exp 1/0/72", out_valid, out_src, out_data); end
    in0_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_mid_join();
    logic       exp_src  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp_data [6] = '{8'hE0, 8'hE1, 8'hF0, 8'hE2, 8'hF1, 8'hE3};
    logic [7:0] da = 8'hE0, db = 8'hF0;
    out_ready = 1'b1; in0_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in0_data = da; in1_data = db; in1_valid = (k >= 2);
      @(posedge clk); #1;
      n_vec++; if ({out_valid, out_src, out_data} !== {1'b1, exp_src[k], exp_data[k]}) begin n_err++; $display("FAIL join_out[%0d] got v=%b s=%b d=%h exp 1/%b/%h", k, out_valid, out_src, out_data, exp_src[k], exp_data[k]); end
      if (exp_src[k]) db = db + 8'h01; else da = da + 8'h01;
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef ARB_MUX_CNT_EN
  task automatic test_counters();
    rst = 1'b1;
    #1;
    n_vec++; if ({grant_cnt0, grant_cnt1} !== 32'h0) begin n_err++; $display("FAIL cnt_rst got %h/%h exp 0000/0000", grant_cnt0, grant_cnt1); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1 in1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 in0_valid = 1'b0;
    n_vec++; if ({grant_cnt0, grant_cnt1} !== {16'd5, 16'd3}) begin n_err++; $display("FAIL cnt_5_3 got %0d/%0d exp 5/3", grant_cnt0, grant_cnt1); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in0_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    n_vec++; if (grant_cnt0 !== 16'hFFFF) begin n_err++; $display("FAIL cnt_max got %h exp ffff", grant_cnt0); end
    @(posedge clk); #1;
    in0_valid = 1'b0;
    n_vec++; if ({grant_cnt0, grant_cnt1} !== 32'h0) begin n_err++; $display("FAIL cnt_wrap got %h/%h exp 0000/0000", grant_cnt0, grant_cnt1); end
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_single_stream();
    test_backpressure();
    test_mid_join();
`ifdef ARB_MUX_CNT_EN
    test_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arb_mux_2_1.md
# arb_mux_2_1

Two-input, one-output arbitrated stream multiplexer: the merge counterpart to the team's 1-to-2 demultiplexer. It takes two valid/ready streams, chooses one word per cycle using round-robin priority, and drives it through one registered output stage, tagged with its source index. It sits in front of any shared consumer that two producers feed, such as a shared FIFO, a UART transmitter or a bus port.

## Interface
Parameters:
- WIDTH, 8, data width in bits of each input and of the output.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in0_data  input  WIDTH  payload from source 0.
- in0_valid  input  1  source 0 presents a word.
- in0_ready  output  1  source 0 word accepted this cycle when high together with in0_valid.
- in1_data  input  WIDTH  payload from source 1.
- in1_valid  input  1  source 1 presents a word.
- in1_ready  output  1  source 1 word accepted this cycle when high together with in1_valid.
- out_data  output  WIDTH  registered payload.
- out_src  output  1  index of the source that produced out_data.
- out_valid  output  1  out_data and out_src are valid.
- out_ready  input  1  consumer accepts the output word.

## Operation
- Output register state: empty or full, represented by out_valid.
- Load enable: load = !out_valid || out_ready.
- Arbitration, combinational, one winner per cycle, using a 1-bit last_grant register:
  - Only one source valid: that source wins.
  - Both sources valid: the source != last_grant wins.
  - Neither source valid: no grant.
- inX_ready = load && (grant == X). Never high for both inputs in the same cycle. Never high for a source that is not granted, even if it is valid.
- Transfer from source X happens when inX_valid && inX_ready. On a transfer:
  - out_data <= inX_data, out_src <= X, out_valid <= 1.
  - last_grant <= X.
- Load with no transfer (out_ready high or register empty, no source valid): out_valid <= 0. out_data and out_src hold their values.
- Output held (out_valid && !out_ready): out_data, out_src and out_valid are stable, and both inX_ready are 0.
- Simultaneous drain and fill: when out_ready is high and a source is valid, the register drains and reloads in the same cycle, so out_valid stays 1.
- Arbitration only advances on an actual transfer. A source that stays valid is never starved: its maximum wait is one transfer from the other source.
- The block imposes no requirement that the valid/data inputs stay stable while ready is low. Standard valid/ready sources do keep them stable.

## Timing
- Latency: 1 cycle from an input transfer edge to out_valid.
- Throughput: 1 word per cycle when out_ready is held high.
- Reset values: out_valid = 0, out_data = 0, out_src = 0, last_grant = 1 (so source 0 wins the first contention).
- Reset asserted mid-operation: the word held in the output register is discarded immediately (asynchronously), and both inX_ready fall to 0 while rst is high.
- First clock edge after reset release: may already accept a word.
- inX_ready depends combinationally on out_ready, out_valid, in0_valid, in1_valid and last_grant. No combinational path from any data input to any ready output.

## Configuration
- Macro: ARB_MUX_CNT_EN.
- When defined, the block adds:
  - grant_cnt0 and grant_cnt1, output, 16 bits each: count transfers from source 0 and source 1 respectively.
  - Counters wrap from 16'hFFFF to 0.
  - Counters reset to 0.
  - Counters update on the same edge as the transfer.
- When not defined: no counter ports and no counter logic. All other behaviour is identical.

## Structure
- Package arb_mux_pkg holds:
  - ARB_MUX_WIDTH_DEF = 8.
  - CNT_W = 16.
  - Source-index constants SRC0 = 1'b0 and SRC1 = 1'b1.
- Sub-module rr_arb_2: the 2-requester round-robin arbiter.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt[1:0] (one-hot or zero), gnt_idx.
  - Purely combinational. The last_grant register stays in the top level.

## Test plan
- Reset: assert rst mid-stream with out_valid = 1 → out_valid, out_data and out_src drop to 0 immediately. After release, with both sources valid, source 0 is granted first.
- Single source streaming: in0 sends 8'h11, 8'h22, 8'h33 on consecutive cycles with out_ready = 1 → out_data shows 11, 22, 33 on consecutive cycles, out_src = 0, in1_ready = 0 throughout.
- Contention: both sources valid every cycle (in0 = 8'hA0.., in1 = 8'hB0..), out_ready = 1 → out_src alternates 0,1,0,1 and out_data alternates A0,B0,A1,B1.
- Backpressure: out_ready = 0 for 3 cycles while full → out_data is held, both readies are 0, and no word is lost. When out_ready returns to 1, the next word appears one cycle later.
- Mid-stream join: in0 streaming alone, then in1 becomes valid → in1 is granted on the next transfer, and grants alternate from then on.
- ARB_MUX_CNT_EN defined: 5 transfers from source 0 and 3 from source 1 → grant_cnt0 = 5, grant_cnt1 = 3. Preloading via 65536 transfers wraps the counter to 0.
